// File: rtl/pc_pkg.sv
// ---------------------------------------------------------------------------
// pc_pkg
// Shared definitions for the instruction-fetch program counter slice:
//   RESET_VEC_DEF : PC loaded on reset (default for fetch_pc RESET_VEC)
//   PC_INC        : sequential fetch increment in bytes
//   pc_sel_e      : next-PC source select, listed in decreasing priority
//   isMisaligned  : helper flagging a target that is not word aligned
// Optional feature macro used by fetch_pc: FETCH_PC_MISALIGN_CHK_EN
// ---------------------------------------------------------------------------
package pc_pkg;

  localparam logic [31:0] RESET_VEC_DEF = 32'hBFC0_0000;
  localparam int unsigned PC_INC        = 4;

  typedef enum logic [2:0] {
    SEL_RST,
    SEL_TRAP,
    SEL_HOLD,
    SEL_JALR,
    SEL_BR,
    SEL_SEQ
  } pc_sel_e;

  // A target is misaligned when either of its two low bits is set.
  function automatic logic isMisaligned(input logic [1:0] lsbs);
    return (lsbs != 2'b00);
  endfunction

endpackage

// File: rtl/ras_stack.sv
// ---------------------------------------------------------------------------
// ras_stack
// Return-address stack kept as a circular buffer. A push writes one slot
// above the current top and advances the top pointer; when the buffer is
// already full the oldest entry is silently overwritten. Pops retreat the
// pointer and are ignored when empty. Push and pop together replace the
// top entry in place (or act as a plain push when empty). Only the pointer
// and the occupancy count are cleared by reset or clear; entry contents
// are never cleared.
// Parameters:
//   XLEN      : entry width in bits
//   RAS_DEPTH : number of entries (power of 2, 2..16)
// Ports:
//   clk   in   clock, rising edge
//   rst   in   synchronous active-low reset (0 = reset)
//   push  in   push din
//   pop   in   pop the top entry
//   clear in   empty the stack (count and top pointer to 0)
//   din   in   value to push / replace with
//   top   out  entry at the top pointer (don't-care when valid=0)
//   valid out  stack non-empty
// ---------------------------------------------------------------------------
module ras_stack
  import pc_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic            clear,
  input  logic [XLEN-1:0] din,
  output logic [XLEN-1:0] top,
  output logic            valid
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(RAS_DEPTH);

  logic [XLEN-1:0] r_mem [RAS_DEPTH];
  logic [PW-1:0]   r_top;
  logic [CW-1:0]   r_count;

  logic            w_empty;
  logic            w_replace;
  logic            w_doPush;
  logic            w_doPop;
  logic            w_live;
  logic [PW-1:0]   w_topInc;
  logic [PW-1:0]   w_topDec;

  // Decode the requested operation. A combined push+pop on a non-empty
  // stack is an in-place replace; on an empty stack it degrades to a push.
  // A pop on an empty stack is dropped entirely so neither the pointer nor
  // the count can underflow. Pointer arithmetic wraps naturally because
  // the depth is a power of two.
  always_comb begin
    w_empty   = (r_count == '0);
    w_live    = rst && !clear;
    w_replace = push && pop && !w_empty;
    w_doPush  = push && !w_replace;
    w_doPop   = pop && !push && !w_empty;
    w_topInc  = r_top + 1'b1;
    w_topDec  = r_top - 1'b1;
  end

  // Pointer and occupancy. Reset and clear both empty the stack; the count
  // saturates at the depth so a push onto a full stack keeps it full while
  // the pointer moves on over the oldest entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_top   <= '0;
      r_count <= '0;
    end else if (clear) begin
      r_top   <= '0;
      r_count <= '0;
    end else if (w_doPush) begin
      r_top   <= w_topInc;
      r_count <= (r_count == FULL_COUNT) ? r_count : r_count + 1'b1;
    end else if (w_doPop) begin
      r_top   <= w_topDec;
      r_count <= r_count - 1'b1;
    end
  end

  // Entry storage. There is deliberately no reset here: contents survive
  // reset and clear, and writes are suppressed on those edges so that a
  // reset arriving mid-operation never leaves a half-applied push behind.
  always_ff @(posedge clk) begin
    if (w_live) begin
      if (w_doPush) begin
        r_mem[w_topInc] <= din;
      end else if (w_replace) begin
        r_mem[r_top] <= din;
      end
    end
  end

  // The prediction is simply whatever sits at the top pointer.
  always_comb begin
    top   = r_mem[r_top];
    valid = !w_empty;
  end

endmodule

// File: rtl/fetch_pc.sv
// ---------------------------------------------------------------------------
// fetch_pc
// Program counter for the fetch stage with a return-address-stack predictor.
// Next-PC priority: reset > trap > stall (hold) > JALR > branch/JAL > pc+4.
// A trap redirects even while stalled and empties the return stack.
// Optional feature macro: FETCH_PC_MISALIGN_CHK_EN
//   defined   : a selected JALR/branch target whose low two bits are not zero
//               redirects to trap_vec instead, pulses misalign for one cycle
//               and leaves the return stack untouched on that edge.
//   undefined : targets are loaded unchecked and misalign is tied to 0.
// Parameters:
//   XLEN      : PC and target width
//   RESET_VEC : PC after reset (and before the first reset in simulation)
//   RAS_DEPTH : return-address-stack entries (power of 2, 2..16)
// Ports:
//   clk       in   clock, rising edge
//   rst       in   synchronous active-low reset (0 = reset)
//   en        in   advance enable; 0 = stall, all state held
//   pc_src    in   take branch/JAL target
//   pc_target in   branch/JAL target
//   jalr      in   JALR in flight
//   alu_out   in   JALR target (rs1+imm)
//   is_call   in   current instruction is a call
//   is_ret    in   current instruction is a return
//   trap      in   trap redirect request
//   trap_vec  in   trap handler address
//   pc        out  current PC
//   pc_plus4  out  pc+4 (combinational, wraps silently)
//   ras_top   out  predicted return address
//   ras_valid out  return stack non-empty
//   misalign  out  registered misaligned-target flag
// ---------------------------------------------------------------------------
module fetch_pc
  import pc_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(RESET_VEC_DEF),
  parameter int              RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            pc_src,
  input  logic [XLEN-1:0] pc_target,
  input  logic            jalr,
  input  logic [XLEN-1:0] alu_out,
  input  logic            is_call,
  input  logic            is_ret,
  input  logic            trap,
  input  logic [XLEN-1:0] trap_vec,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] ras_top,
  output logic            ras_valid,
  output logic            misalign
);

  // The declaration value gives simulation a defined PC before the first
  // reset edge; synthesis targets that honour register init values use it
  // too, and the synchronous reset covers everything else.
  logic [XLEN-1:0] r_pc = RESET_VEC;

  pc_sel_e         w_sel;
  logic [XLEN-1:0] w_pcPlus4;
  logic [XLEN-1:0] w_jalrTarget;
  logic [XLEN-1:0] w_nextPc;
  logic            w_misTake;
  logic            w_rasEn;
  logic            w_push;
  logic            w_pop;
  logic            w_clear;

  // Sequential successor and the JALR target with bit 0 forced low.
  always_comb begin
    w_pcPlus4    = r_pc + XLEN'(PC_INC);
    w_jalrTarget = {alu_out[XLEN-1:1], 1'b0};
  end

  // Resolve the next-PC source strictly by priority. JALR beats a
  // simultaneous branch because the JALR target is the later-computed,
  // architecturally correct one.
  always_comb begin
    w_sel = SEL_SEQ;
    if (!rst) begin
      w_sel = SEL_RST;
    end else if (trap) begin
      w_sel = SEL_TRAP;
    end else if (!en) begin
      w_sel = SEL_HOLD;
    end else if (jalr) begin
      w_sel = SEL_JALR;
    end else if (pc_src) begin
      w_sel = SEL_BR;
    end
  end

  // Misaligned-target detection. For JALR the raw alu_out low bits are
  // examined, so an odd rs1+imm is reported even though bit 0 would
  // otherwise be cleared when forming the target.
  always_comb begin
    w_misTake = 1'b0;
`ifdef FETCH_PC_MISALIGN_CHK_EN
    if (w_sel == SEL_JALR) begin
      w_misTake = isMisaligned(alu_out[1:0]);
    end else if (w_sel == SEL_BR) begin
      w_misTake = isMisaligned(pc_target[1:0]);
    end
`endif
  end

  // Next-PC mux. A misaligned redirect (only possible with the check
  // enabled) is diverted to the trap handler.
  always_comb begin
    w_nextPc = w_pcPlus4;
    case (w_sel)
      SEL_RST:  w_nextPc = RESET_VEC;
      SEL_TRAP: w_nextPc = trap_vec;
      SEL_HOLD: w_nextPc = r_pc;
      SEL_JALR: w_nextPc = w_misTake ? trap_vec : w_jalrTarget;
      SEL_BR:   w_nextPc = w_misTake ? trap_vec : pc_target;
      SEL_SEQ:  w_nextPc = w_pcPlus4;
      default:  w_nextPc = w_pcPlus4;
    endcase
  end

  // The return stack only moves on an edge where the PC genuinely
  // advances: not in reset, trap, stall, or a misaligned diversion.
  // Traps empty it in the same edge they redirect the PC.
  always_comb begin
    w_rasEn = ((w_sel == SEL_JALR) || (w_sel == SEL_BR) || (w_sel == SEL_SEQ))
              && !w_misTake;
    w_push  = w_rasEn && is_call;
    w_pop   = w_rasEn && is_ret;
    w_clear = (w_sel == SEL_TRAP);
  end

  // PC register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc <= RESET_VEC;
    end else begin
      r_pc <= w_nextPc;
    end
  end

`ifdef FETCH_PC_MISALIGN_CHK_EN
  logic r_misalign;

  // The flag is rewritten every edge, so it is high for exactly the one
  // cycle following the diverted redirect.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= w_misTake;
    end
  end

  assign misalign = r_misalign;
`else
  assign misalign = 1'b0;
`endif

  ras_stack #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .clear (w_clear),
    .din   (w_pcPlus4),
    .top   (ras_top),
    .valid (ras_valid)
  );

  assign pc       = r_pc;
  assign pc_plus4 = w_pcPlus4;

endmodule

// File: tb/tb_fetch_pc.sv
// ---------------------------------------------------------------------------
// tb_fetch_pc
// Directed bench for fetch_pc. Each step drives inputs, advances a
// behavioural model (PC priority plus a queue-based return stack) and
// pushes the expected post-edge state onto a scoreboard; after the edge the
// entry is popped and compared against the DUT outputs.
// Honours FETCH_PC_MISALIGN_CHK_EN when it is defined for the build.
// ---------------------------------------------------------------------------
module tb_fetch_pc;

  localparam int          XLEN  = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RV    = 32'hBFC0_0000;
  localparam logic [31:0] TV    = 32'h0000_0080;

  logic        clk = 1'b0;
  logic        rst, en, pc_src, jalr, is_call, is_ret, trap;
  logic [31:0] pc_target, alu_out, trap_vec;
  logic [31:0] pc, pc_plus4, ras_top;
  logic        ras_valid, misalign;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        valid;
    logic [31:0] top;
    logic        mis;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;

  logic [31:0] mPc;
  logic [31:0] mStk[$];
  logic        mMis;

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  fetch_pc #(
    .XLEN      (XLEN),
    .RESET_VEC (RV),
    .RAS_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .pc_src    (pc_src),
    .pc_target (pc_target),
    .jalr      (jalr),
    .alu_out   (alu_out),
    .is_call   (is_call),
    .is_ret    (is_ret),
    .trap      (trap),
    .trap_vec  (trap_vec),
    .pc        (pc),
    .pc_plus4  (pc_plus4),
    .ras_top   (ras_top),
    .ras_valid (ras_valid),
    .misalign  (misalign)
  );

  // Single comparison point: counts, asserts, reports on failure.
  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Behavioural model of one rising edge, using the currently driven inputs.
  task automatic modelEdge();
    logic [31:0] oldPc;
    logic [31:0] tgt;
    logic        mis;
    oldPc = mPc;
    mis   = 1'b0;
    if (!rst) begin
      mPc = RV;
      mStk.delete();
      mMis = 1'b0;
    end else if (trap) begin
      mPc = trap_vec;
      mStk.delete();
      mMis = 1'b0;
    end else if (!en) begin
      mMis = 1'b0;
    end else begin
      if (jalr)        tgt = alu_out & ~32'd1;
      else if (pc_src) tgt = pc_target;
      else             tgt = oldPc + 32'd4;
`ifdef FETCH_PC_MISALIGN_CHK_EN
      if (jalr)        mis = (alu_out[1:0] != 2'b00);
      else if (pc_src) mis = (pc_target[1:0] != 2'b00);
`endif
      if (mis) begin
        mPc  = trap_vec;
        mMis = 1'b1;
      end else begin
        mMis = 1'b0;
        if (is_call && is_ret) begin
          if (mStk.size() == 0) mStk.push_back(oldPc + 32'd4);
          else                  mStk[mStk.size()-1] = oldPc + 32'd4;
        end else if (is_call) begin
          mStk.push_back(oldPc + 32'd4);
          if (mStk.size() > DEPTH) void'(mStk.pop_front());
        end else if (is_ret && mStk.size() != 0) begin
          void'(mStk.pop_back());
        end
        mPc = tgt;
      end
    end
  endtask

  // Compare the DUT against the oldest pending expectation.
  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("[TB] FAIL scoreboard: observed=empty expected=entry");
      return;
    end
    e = sb.pop_front();
    checkVal({e.tag, ".pc"},       pc,        e.pc);
    checkVal({e.tag, ".pc_plus4"}, pc_plus4,  e.pc + 32'd4);
    checkVal({e.tag, ".valid"},    {31'd0, ras_valid}, {31'd0, e.valid});
    if (e.valid) checkVal({e.tag, ".ras_top"}, ras_top, e.top);
    checkVal({e.tag, ".misalign"}, {31'd0, misalign},  {31'd0, e.mis});
  endtask

  // Drive one step, record the model's expectation, clock, then check.
  task automatic applyStimulus(input string tag, input logic r, input logic e,
                               input logic ps, input logic [31:0] tgt,
                               input logic j, input logic [31:0] alu,
                               input logic call, input logic ret,
                               input logic trp, input logic [31:0] tv);
    exp_t x;
    rst = r; en = e; pc_src = ps; pc_target = tgt; jalr = j; alu_out = alu;
    is_call = call; is_ret = ret; trap = trp; trap_vec = tv;
    modelEdge();
    x.tag   = tag;
    x.pc    = mPc;
    x.valid = (mStk.size() != 0);
    x.top   = (mStk.size() != 0) ? mStk[mStk.size()-1] : 32'd0;
    x.mis   = mMis;
    sb.push_back(x);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0; en = 1'b0; pc_src = 1'b0; jalr = 1'b0; is_call = 1'b0;
    is_ret = 1'b0; trap = 1'b0; pc_target = '0; alu_out = '0; trap_vec = TV;
    mPc  = RV;
    mMis = 1'b0;

    #1;
    checkVal("init.pc", pc, RV);

    // reset, then straight-line fetch
    applyStimulus("reset", 0, 1, 0, 0, 0, 0, 1, 0, 0, TV);
    applyStimulus("seq1",  1, 1, 0, 0, 0, 0, 0, 0, 0, TV);
    applyStimulus("seq2",  1, 1, 0, 0, 0, 0, 0, 0, 0, TV);
    applyStimulus("seq3",  1, 1, 0, 0, 0, 0, 0, 0, 0, TV);
    applyStimulus("seq4",  1, 1, 0, 0, 0, 0, 0, 0, 0, TV);

    // JALR wins over branch, bit 0 cleared (or misaligned diversion)
    applyStimulus("jalr_pri", 1, 1, 1, 32'h1234_5678, 1, 32'h8000_0021, 0, 0, 0, TV);

    // pc+4 wraparound
    applyStimulus("wrap_set", 1, 1, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, TV);
    applyStimulus("wrap_seq", 1, 1, 0, 0, 0, 0, 0, 0, 0, TV);

    // unaligned branch target
    applyStimulus("br_odd", 1, 1, 1, 32'h0000_0202, 0, 0, 0, 0, 0, TV);

    // five calls into a four-entry stack
    applyStimulus("go100", 1, 1, 1, 32'h0000_0100, 0, 0, 0, 0, 0, TV);
    for (int i = 1; i <= 5; i++) begin
      applyStimulus($sformatf("call%0d", i), 1, 1, 1, 32'((i + 1) * 32'h100),
                    0, 0, 1, 0, 0, TV);
    end

    // returns via JALR back to 0x600; tops 404, 304, 204
    for (int i = 1; i <= 3; i++) begin
      applyStimulus($sformatf("pop%0d", i), 1, 1, 0, 0, 1, 32'h0000_0600, 0, 1, 0, TV);
    end

    // call and return together at pc=600 replaces 204 with 604
    applyStimulus("callret", 1, 1, 0, 0, 1, 32'h0000_0600, 1, 1, 0, TV);
    applyStimulus("pop4",    1, 1, 0, 0, 1, 32'h0000_0600, 0, 1, 0, TV);
    applyStimulus("pop_mt",  1, 1, 0, 0, 1, 32'h0000_0600, 0, 1, 0, TV);
    applyStimulus("push_a",  1, 1, 0, 0, 1, 32'h0000_0700, 1, 0, 0, TV);
    applyStimulus("pop_a",   1, 1, 0, 0, 1, 32'h0000_0600, 0, 1, 0, TV);
    applyStimulus("callret_mt", 1, 1, 0, 0, 1, 32'h0000_0800, 1, 1, 0, TV);

    // stall holds pc and stack, then trap while stalled
    applyStimulus("push_b", 1, 1, 1, 32'h0000_0900, 0, 0, 1, 0, 0, TV);
    for (int i = 1; i <= 3; i++) begin
      applyStimulus($sformatf("stall%0d", i), 1, 0, 1, 32'h0000_0A00, 0, 0, 1, 0, 0, TV);
    end
    applyStimulus("trap_stall", 1, 0, 1, 32'h0000_0A00, 0, 0, 1, 0, 1, TV);

    // trap while enabled with a call pending
    applyStimulus("push_c",   1, 1, 1, 32'h0000_0B00, 0, 0, 1, 0, 0, TV);
    applyStimulus("trap_run", 1, 1, 1, 32'h0000_0C00, 0, 0, 1, 0, 1, 32'h0000_0040);

    // reset mid-sequence with a call asserted
    applyStimulus("push_d",    1, 1, 1, 32'h0000_0D00, 0, 0, 1, 0, 0, TV);
    applyStimulus("rst_call",  0, 1, 1, 32'h0000_0E00, 0, 0, 1, 0, 0, TV);
    applyStimulus("after_rst", 1, 1, 0, 0, 0, 0, 0, 0, 0, TV);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
